wb_master_bridge: RTL and testbench
===================================

// Module: wb_master_bridge
// PURPOSE
//  Wishbone classic single-access initiator for the MMIO fabric. It turns a command
//  stream (from the host bridge/CPU side) into single-beat CYC/STB cycles to MMIO slaves
//  (timer, GPIO, ...) and returns read data or a timeout error on a response stream.
//  One transaction is outstanding at a time.
// PARAMETERS
//  ADDR_W   32   Wishbone address width.
//  DATA_W   32   Wishbone data width.
//  TIMEOUT  256  Cycles to wait for ACK before aborting. Must be >= 1; an elaboration-time assert enforces it.
// PORTS
//  CLK        in   1       System clock; all logic is on the rising edge.
//  RST_N      in   1       Asynchronous, active-low reset.
//  cmd_valid  in   1       Command present.
//  cmd_ready  out  1       Bridge accepts a command (state IDLE).
//  cmd_we     in   1       1 = write, 0 = read.
//  cmd_addr   in   ADDR_W  Target word address.
//  cmd_wdata  in   DATA_W  Write data; ignored for reads.
//  rsp_valid  out  1       Response present.
//  rsp_ready  in   1       Consumer takes the response.
//  rsp_rdata  out  DATA_W  Read data; 0 for writes and for timeouts.
//  rsp_err    out  1       1 = no ACK within TIMEOUT cycles.
//  ADDR       out  ADDR_W  Wishbone address.
//  DAT_O      out  DATA_W  Wishbone write data.
//  DAT_I      in   DATA_W  Wishbone read data.
//  WE         out  1       Wishbone write enable.
//  CYC        out  1       Wishbone cycle.
//  STB        out  1       Wishbone strobe.
//  ACK        in   1       Wishbone acknowledge.
// BEHAVIOUR
//  - Reset values: CYC=STB=WE=0; ADDR=DAT_O=0; rsp_valid=0; rsp_rdata=0; rsp_err=0;
//    state=IDLE; timeout counter=0.
//  - FSM states: IDLE -> BUS -> RESP -> IDLE.
//  - IDLE:
//    - cmd_ready=1.
//    - On cmd_valid, register we/addr/wdata into WE/ADDR/DAT_O and set CYC=STB=1
//      (registered outputs, visible the next cycle), clear the counter, go to BUS.
//  - BUS:
//    - CYC, STB, ADDR, WE and DAT_O are held stable. The counter increments once per cycle.
//    - ACK sampled high: capture DAT_I into rsp_rdata (0 if write), rsp_err=0, drop CYC/STB, go to RESP.
//    - Else, counter == TIMEOUT-1: rsp_rdata=0, rsp_err=1, drop CYC/STB, go to RESP.
//    - ACK and timeout in the same cycle: ACK wins, rsp_err=0.
//  - RESP:
//    - rsp_valid=1; rsp_rdata and rsp_err are stable until rsp_ready. CYC=STB=0.
//    - On rsp_ready, go to IDLE (rsp_valid=0 next cycle).
//  - ACK is ignored outside BUS. Slaves with a registered ACK may hold ACK for one extra
//    cycle after STB drops; that ACK must not complete anything.
//  - Minimum latency: command accept -> STB high 1 cycle; zero-wait slave with registered
//    ACK -> rsp_valid 2 cycles after STB rises.
//  - Back-to-back commands: CYC/STB stay low for at least 2 cycles (RESP and IDLE) between
//    transactions. No pipelined or burst cycles.
//  - Reset mid-operation: RST_N low forces CYC/STB low immediately (asynchronously) and
//    discards any pending response; no response is issued for the aborted command.
//  - Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
// STRUCTURE
//  - Package wb_master_pkg:
//    - typedef enum logic [1:0] {IDLE, BUS, RESP} wbm_state_t.
//    - localparam WBM_TIMEOUT_DEFAULT = 256.
//  - Single module. No sub-module is warranted; the counter is a few lines inside the FSM.
//  - Wishbone signals are discrete ports so one instance can drive a wishbone_if through
//    top-level assigns.
// TESTING (bench pairs the bridge with dev_timer, whose RST is driven by !RST_N, plus a
//  stub slave with ACK tied 0)
//  1. Write addr 2, data 32'h1 -> one BUS cycle; the first rising ACK is sampled with
//     CYC=STB=1; rsp_err=0, rsp_rdata=0; the timer starts counting.
//  2. 10 cycles later, read addr 0 -> rsp_rdata > 0 and increases on a repeated read;
//     read addr 1 -> 32'h0 (upper count word).
//  3. Command to the stub slave, TIMEOUT=16 -> STB high exactly 16 cycles;
//     rsp_err=1, rsp_rdata=0.
//  4. Stub ACK asserted on the cycle where counter==TIMEOUT-1 -> rsp_err=0, DAT_I is captured.
//  5. rsp_ready held low 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable;
//     cmd_ready=0; a new cmd_valid is not accepted.
//  6. RST_N pulsed low during BUS -> CYC/STB drop in the same cycle; no rsp_valid follows;
//     the next command completes normally.

Source files
------------

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared state type and defaults for the Wishbone single-access initiator.
package wb_master_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RESP} wbm_state_t;
    localparam int WBM_TIMEOUT_DEFAULT = 256;
endpackage

// File: rtl/wb_master_bridge.sv
// wb_master_bridge: turns a command stream into single-beat Wishbone classic cycles with an ACK timeout.
module wb_master_bridge
    import wb_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = WBM_TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DAT_O,
    input  logic [DATA_W-1:0] DAT_I,
    output logic              WE,
    output logic              CYC,
    output logic              STB,
    input  logic              ACK
);
    localparam int CW = $clog2(TIMEOUT + 1);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("wb_master_bridge: TIMEOUT must be >= 1");
    end

    wbm_state_t        state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              we_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;

    // CYC/STB decode straight from the state register, so async reset drops them at once
    assign CYC       = (state == BUS);
    assign STB       = (state == BUS);
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we_d    = WE;
        addr_d  = ADDR;
        wdata_d = DAT_O;
        rdata_d = rsp_rdata;
        err_d   = rsp_err;
        case (state)
            IDLE: if (cmd_valid) begin
                state_d = BUS;
                cnt_d   = '0;
                we_d    = cmd_we;
                addr_d  = cmd_addr;
                wdata_d = cmd_wdata;
            end
            BUS: begin
                cnt_d = (cnt == CW'(TIMEOUT)) ? cnt : cnt + CW'(1);
                if (ACK) begin
                    state_d = RESP;
                    rdata_d = WE ? '0 : DAT_I;
                    err_d   = 1'b0;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            WE        <= 1'b0;
            ADDR      <= '0;
            DAT_O     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            WE        <= we_d;
            ADDR      <= addr_d;
            DAT_O     <= wdata_d;
            rsp_rdata <= rdata_d;
            rsp_err   <= err_d;
        end
    end
endmodule

// File: tb/tb_wb_master_bridge.sv
// tb_wb_master_bridge: directed and randomized transactions against a small memory slave with programmable ACK timing.
module tb_wb_master_bridge;
    localparam int TO = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata, ADDR, DAT_O, DAT_I;
    logic        WE, CYC, STB, ACK;

    int n_cmp = 0;
    int n_err = 0;

    // Slave: ACK high during the ack_at-th STB cycle (0 = never); optional ghost ACK one cycle later
    int          ack_at = 0;
    int          stb_n = 0;
    logic        ghost = 1'b0, ack_prev = 1'b0, ack_core;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];

    assign ack_core = CYC && STB && (stb_n + 1 == ack_at);
    assign ACK      = ack_core || (ghost && ack_prev);
    assign DAT_I    = mem[ADDR[3:0]];

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stb_n    <= 0;
            ack_prev <= 1'b0;
        end else begin
            stb_n    <= (CYC && STB) ? stb_n + 1 : 0;
            ack_prev <= ack_core;
            if (ack_core && WE) mem[ADDR[3:0]] <= DAT_O;
        end
    end

    always #5 CLK = ~CLK;

    wb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ADDR(ADDR), .DAT_O(DAT_O), .DAT_I(DAT_I), .WE(WE), .CYC(CYC), .STB(STB), .ACK(ACK)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; expectations come from the ACK position relative to the timeout window
    task automatic txn(input logic we, input logic [3:0] a, input logic [31:0] wd,
                       input int d, input int hold, input logic gh);
        int          n;
        logic        exp_err;
        logic [31:0] exp_rd;
        @(negedge CLK);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = {28'd0, a}; cmd_wdata = wd;
        ack_at = d; ghost = gh;
        @(negedge CLK);
        cmd_valid = 1'b0;
        chk("stb_after_accept", {30'd0, CYC, STB}, 32'd3);
        chk("addr", ADDR, {28'd0, a});
        chk("we", {31'd0, WE}, {31'd0, we});
        if (we) chk("dat_o", DAT_O, wd);
        n = 1;
        while (STB && n <= 4 * TO) begin
            @(negedge CLK);
            if (STB) begin
                n++;
                chk("bus_hold_addr", ADDR, {28'd0, a});
            end
        end
        exp_err = !(d >= 1 && d <= TO);
        exp_rd  = (exp_err || we) ? 32'd0 : ref_mem[a];
        if (!exp_err && we) ref_mem[a] = wd;
        chk("stb_cycles", n, exp_err ? TO : d);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(negedge CLK);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
            chk("hold_busy", {30'd0, cmd_ready, CYC}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        chk("rsp_done", {29'd0, rsp_valid, cmd_ready, CYC}, 32'd2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        #12;
        chk("rst_bus", {29'd0, CYC, STB, WE}, 32'd0);
        chk("rst_addr", ADDR, 32'd0);
        chk("rst_dato", DAT_O, 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge CLK);
        RST_N = 1'b1;

        txn(1'b1, 4'd2, 32'h1, 2, 0, 1'b0);
        txn(1'b0, 4'd2, 32'h0, 2, 0, 1'b0);
        txn(1'b0, 4'd0, 32'h0, 1, 0, 1'b0);
        txn(1'b0, 4'd5, 32'h0, 0, 0, 1'b0);
        txn(1'b1, 4'd6, 32'hdead_beef, 0, 0, 1'b0);
        txn(1'b0, 4'd7, 32'h0, TO, 0, 1'b0);
        txn(1'b0, 4'd8, 32'h0, TO + 1, 0, 1'b0);
        txn(1'b0, 4'd9, 32'h0, 3, 5, 1'b1);
        txn(1'b1, 4'd9, 32'h1234_5678, 1, 2, 1'b1);
        txn(1'b0, 4'd9, 32'h0, 4, 0, 1'b0);

        // Asynchronous reset while the bus cycle is open
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'd3; ack_at = 0;
        @(negedge CLK);
        cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre_rst_stb", {30'd0, CYC, STB}, 32'd3);
        #2 RST_N = 1'b0;
        #1 chk("async_rst_stb", {30'd0, CYC, STB}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("no_rsp_after_rst", {30'd0, rsp_valid, CYC}, 32'd0);
        end
        txn(1'b0, 4'd3, 32'h0, 2, 0, 1'b0);

        for (int k = 0; k < 25; k++)
            txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                int'($urandom_range(0, TO + 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
